// File: rtl/ps2_matrix_keys.sv
// ps2_matrix_keys: PS/2 set-2 scan-code parser feeding a ROWS x COLS key matrix.
// Handles E0/F0/E1 prefixes and keeps modifiers outside the matrix.
// Scan-code lookup is external (map_* ports) with MAP_LAT cycles of latency.
// Optional keyboard LED update path: `define KEYS_LED_TX_EN.
module ps2_matrix_keys #(
  parameter int                     ROWS      = 8,
  parameter int                     COLS      = 8,
  parameter int                     NMOD      = 4,
  parameter logic [NMOD-1:0][8:0]   MOD_CODES = '0,
  parameter int                     MAP_LAT   = 1,
  localparam int                    RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int                    CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_dsr,
  input  logic [7:0]      rx_q,
  output logic            rx_rden,
  input  logic            tx_busy,
  output logic            tx_wren,
  output logic [7:0]      tx_d,
  output logic [7:0]      map_code,
  output logic            map_ext,
  input  logic [RW-1:0]   map_row,
  input  logic [CW-1:0]   map_col,
  input  logic            map_err,
  input  logic            mask,
  input  logic [ROWS-1:0] rowselect,
  output logic [COLS-1:0] rowbits,
  output logic [NMOD-1:0] key_mod,
  output logic            key_pause,
  output logic            key_clear
`ifdef KEYS_LED_TX_EN
  ,
  input  logic [2:0]      led_state
`endif
);

  // LED states are only reachable when the LED update path is compiled in.
  typedef enum logic [3:0] {
    S_INIT, S_INIT_W, S_IDLE, S_RD, S_DEC, S_SKIP, S_SKIP_RD,
    S_LOOK, S_APPLY, S_FLUSH, S_LED_TW, S_LED_RW, S_LED_RR
  } state_e;

  localparam logic [1:0] LAT_INIT = (MAP_LAT > 0) ? 2'(MAP_LAT - 1) : 2'd0;

  state_e                     state_q, state_d;
  logic [7:0]                 byte_q, byte_d;
  logic                       ext_q, ext_d, brk_q, brk_d;
  logic [2:0]                 skip_q, skip_d;
  logic [1:0]                 lat_q, lat_d;
  logic [ROWS-1:0][COLS-1:0]  matrix_q, matrix_d;
  logic [NMOD-1:0]            key_mod_q, key_mod_d;
  logic [COLS-1:0]            rowbits_q, rowbits_d;
  logic                       rx_rden_q, rx_rden_d, tx_wren_q, tx_wren_d;
  logic [7:0]                 tx_d_q, tx_d_d, map_code_q, map_code_d;
  logic                       map_ext_q, map_ext_d;
  logic                       key_pause_q, key_pause_d, key_clear_q, key_clear_d;
  logic                       mod_hit, pos_ok;
  int                         mod_idx;
`ifdef KEYS_LED_TX_EN
  logic [2:0]                 led_q, led_sent_q, led_sent_d;
  logic                       led_ph_q, led_ph_d;
`endif

  // Modifier match (lowest index wins) and matrix position range check.
  always_comb begin
    mod_hit = 1'b0;
    mod_idx = 0;
    for (int i = NMOD - 1; i >= 0; i--) begin
      if (MOD_CODES[i] == {map_ext_q, map_code_q}) begin
        mod_hit = 1'b1;
        mod_idx = i;
      end
    end
    pos_ok = (int'(map_row) < ROWS) && (int'(map_col) < COLS);
  end

  // OR of all selected rows, registered below.
  always_comb begin
    rowbits_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rowselect[r]) rowbits_d = rowbits_d | matrix_q[r];
    end
  end

  // Next-state and datapath updates for the parser FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d     = state_q;
    byte_d      = byte_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    skip_d      = skip_q;
    lat_d       = lat_q;
    matrix_d    = matrix_q;
    key_mod_d   = key_mod_q;
    rx_rden_d   = 1'b0;
    tx_wren_d   = 1'b0;
    tx_d_d      = tx_d_q;
    map_code_d  = map_code_q;
    map_ext_d   = map_ext_q;
    key_pause_d = 1'b0;
    key_clear_d = 1'b0;
`ifdef KEYS_LED_TX_EN
    led_sent_d  = led_sent_q;
    led_ph_d    = led_ph_q;
`endif
    unique case (state_q)
      S_INIT: begin
        tx_wren_d = 1'b1;
        tx_d_d    = 8'hF4;
        state_d   = S_INIT_W;
      end
      // The strobe cycle itself is skipped so ps2tx has time to raise busy.
      S_INIT_W: if (!tx_wren_q && !tx_busy) state_d = S_IDLE;
      S_IDLE: begin
        if (rx_dsr) begin
          rx_rden_d = 1'b1;
          state_d   = S_RD;
        end
`ifdef KEYS_LED_TX_EN
        else if (led_q != led_sent_q) begin
          tx_wren_d  = 1'b1;
          tx_d_d     = 8'hED;
          led_sent_d = led_q;
          led_ph_d   = 1'b0;
          state_d    = S_LED_TW;
        end
`endif
      end
      S_RD: begin
        byte_d  = rx_q;
        state_d = S_DEC;
      end
      S_DEC: begin
        state_d = S_IDLE;
        case (byte_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hE1: begin
            skip_d  = 3'd7;
            state_d = S_SKIP;
          end
          8'hAA, 8'h00, 8'hFF: state_d = S_FLUSH;
          default: begin
            map_code_d = byte_q;
            map_ext_d  = ext_q;
            lat_d      = LAT_INIT;
            state_d    = (MAP_LAT == 0) ? S_APPLY : S_LOOK;
          end
        endcase
      end
      S_SKIP: begin
        if (skip_q == 3'd0) begin
          key_pause_d = 1'b1;
          state_d     = S_IDLE;
        end else if (rx_dsr) begin
          rx_rden_d = 1'b1;
          state_d   = S_SKIP_RD;
        end
      end
      S_SKIP_RD: begin
        skip_d  = skip_q - 3'd1;
        state_d = S_SKIP;
      end
      S_LOOK: begin
        if (lat_q == 2'd0) state_d = S_APPLY;
        else               lat_d   = lat_q - 2'd1;
      end
      S_APPLY: begin
        if (mod_hit) begin
          key_mod_d[mod_idx] = !brk_q;
        end else if (!map_err && pos_ok) begin
          // Breaks ignore mask so a key pressed before the OSD opened cannot stick.
          if (brk_q)      matrix_d[map_row][map_col] = 1'b0;
          else if (!mask) matrix_d[map_row][map_col] = 1'b1;
        end
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        matrix_d    = '0;
        key_mod_d   = '0;
        key_clear_d = 1'b1;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
        state_d     = S_IDLE;
      end
`ifdef KEYS_LED_TX_EN
      S_LED_TW: if (!tx_wren_q && !tx_busy) state_d = S_LED_RW;
      S_LED_RW: begin
        if (rx_dsr) begin
          rx_rden_d = 1'b1;
          state_d   = S_LED_RR;
        end
      end
      S_LED_RR: begin
        state_d = S_IDLE;
        if (!led_ph_q && rx_q == 8'hFA) begin
          tx_wren_d  = 1'b1;
          tx_d_d     = {5'b0, led_q};
          led_sent_d = led_q;
          led_ph_d   = 1'b1;
          state_d    = S_LED_TW;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      lat_q       <= '0;
      // NOTE: the matrix is a small flop array that must read as all-released
      // after reset, so it is reset like any other state (not a RAM).
      matrix_q    <= '0;
      key_mod_q   <= '0;
      rowbits_q   <= '0;
      rx_rden_q   <= 1'b0;
      tx_wren_q   <= 1'b0;
      tx_d_q      <= '0;
      map_code_q  <= '0;
      map_ext_q   <= 1'b0;
      key_pause_q <= 1'b0;
      key_clear_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_q      <= skip_d;
      lat_q       <= lat_d;
      matrix_q    <= matrix_d;
      key_mod_q   <= key_mod_d;
      rowbits_q   <= rowbits_d;
      rx_rden_q   <= rx_rden_d;
      tx_wren_q   <= tx_wren_d;
      tx_d_q      <= tx_d_d;
      map_code_q  <= map_code_d;
      map_ext_q   <= map_ext_d;
      key_pause_q <= key_pause_d;
      key_clear_q <= key_clear_d;
    end
  end

`ifdef KEYS_LED_TX_EN
  // LED state sampling and record of the last value sent to the keyboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      led_sent_q <= '0;
      led_ph_q   <= 1'b0;
    end else begin
      led_q      <= led_state;
      led_sent_q <= led_sent_d;
      led_ph_q   <= led_ph_d;
    end
  end
`endif

  assign rx_rden   = rx_rden_q;
  assign tx_wren   = tx_wren_q;
  assign tx_d      = tx_d_q;
  assign map_code  = map_code_q;
  assign map_ext   = map_ext_q;
  assign rowbits   = rowbits_q;
  assign key_mod   = key_mod_q;
  assign key_pause = key_pause_q;
  assign key_clear = key_clear_q;

endmodule

// File: tb/tb_ps2_matrix_keys.sv
// Testbench for ps2_matrix_keys: table-driven byte vectors plus hand-written
// sequences for reset/F4, Pause skipping, flush and mid-prefix reset.
module tb_ps2_matrix_keys;

  localparam logic [3:0][8:0] MODS = {9'h175, 9'h000, 9'h175, 9'h012};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_dsr = 1'b0;
  logic [7:0] rx_q = 8'h00;
  logic       rx_rden;
  logic       tx_busy;
  logic       tx_wren;
  logic [7:0] tx_d;
  logic [7:0] map_code;
  logic       map_ext;
  logic [2:0] map_row;
  logic [2:0] map_col;
  logic       map_err;
  logic       mask = 1'b0;
  logic [7:0] rowselect = 8'h00;
  logic [7:0] rowbits;
  logic [3:0] key_mod;
  logic       key_pause;
  logic       key_clear;
`ifdef KEYS_LED_TX_EN
  logic [2:0] led_state = 3'b000;
`endif

  ps2_matrix_keys #(
    .ROWS(8), .COLS(8), .NMOD(4), .MOD_CODES(MODS), .MAP_LAT(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_dsr(rx_dsr), .rx_q(rx_q), .rx_rden(rx_rden),
    .tx_busy(tx_busy), .tx_wren(tx_wren), .tx_d(tx_d),
    .map_code(map_code), .map_ext(map_ext),
    .map_row(map_row), .map_col(map_col), .map_err(map_err),
    .mask(mask), .rowselect(rowselect), .rowbits(rowbits),
    .key_mod(key_mod), .key_pause(key_pause), .key_clear(key_clear)
`ifdef KEYS_LED_TX_EN
    , .led_state(led_state)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Layout lookup model, one cycle of latency: returns {err,row,col}.
  function automatic logic [6:0] lut(input logic ext, input logic [7:0] c);
    if (!ext) begin
      case (c)
        8'h1C: return {1'b0, 3'd2, 3'd5};
        8'h1B: return {1'b0, 3'd3, 3'd1};
        8'h23: return {1'b0, 3'd0, 3'd7};
        8'h12: return {1'b0, 3'd1, 3'd0};
        8'h14: return {1'b0, 3'd4, 3'd4};
        8'h77: return {1'b0, 3'd5, 3'd3};
        default: return {1'b1, 6'd0};
      endcase
    end
    if (c == 8'h75) return {1'b0, 3'd6, 3'd6};
    return {1'b1, 6'd0};
  endfunction

  always @(posedge clk) {map_err, map_row, map_col} <= lut(map_ext, map_code);

  // ps2tx model: logs every written byte and stays busy for a few cycles.
  int busy_cnt = 0;
  logic [7:0] tx_log[$];
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_wren) begin
      tx_log.push_back(tx_d);
      busy_cnt <= 4;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Pulse monitors: count cycles each strobe is high.
  int pause_cnt = 0;
  int clear_cnt = 0;
  always @(negedge clk) begin
    if (key_pause) pause_cnt <= pause_cnt + 1;
    if (key_clear) clear_cnt <= clear_cnt + 1;
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Present one byte as ps2rx would and hold it until the read strobe.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    @(negedge clk);
    rx_q   = b;
    rx_dsr = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rx_rden) got = 1'b1;
    end
    rx_dsr = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rx_rden timeout: byte %0h not read within 40 cycles", b);
    end
  endtask

  task automatic send_and_settle(input logic [7:0] b);
    send_byte(b);
    settle(8);
  endtask

  typedef struct {
    bit         snd;
    logic [7:0] b;
    logic       msk;
    logic [7:0] rsel;
    logic [7:0] rows;
    logic [3:0] mods;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit s, input logic [7:0] b, input logic m,
                     input logic [7:0] rs, input logic [7:0] rw, input logic [3:0] md);
    vec_t v;
    v.snd = s; v.b = b; v.msk = m; v.rsel = rs; v.rows = rw; v.mods = md;
    vecs.push_back(v);
  endtask

  initial begin
    int n0;
    int p0;
    int c0;

    // Make/break, extended modifier, plain modifier, mask, lookup error,
    // multiple keys and row-select combinations.
    add(1, 8'h1C, 0, 8'h04, 8'h20, 4'h0);
    add(1, 8'hF0, 0, 8'h04, 8'h20, 4'h0);
    add(1, 8'h1C, 0, 8'h04, 8'h00, 4'h0);
    add(1, 8'hE0, 0, 8'h40, 8'h00, 4'h0);
    add(1, 8'h75, 0, 8'h40, 8'h00, 4'h2);
    add(1, 8'hE0, 0, 8'h40, 8'h00, 4'h2);
    add(1, 8'hF0, 0, 8'h40, 8'h00, 4'h2);
    add(1, 8'h75, 0, 8'h40, 8'h00, 4'h0);
    add(1, 8'h12, 0, 8'h02, 8'h00, 4'h1);
    add(1, 8'hF0, 0, 8'h02, 8'h00, 4'h1);
    add(1, 8'h12, 0, 8'h02, 8'h00, 4'h0);
    add(1, 8'h1C, 1, 8'h04, 8'h00, 4'h0);
    add(1, 8'h1C, 0, 8'h04, 8'h20, 4'h0);
    add(1, 8'hF0, 1, 8'h04, 8'h20, 4'h0);
    add(1, 8'h1C, 1, 8'h04, 8'h00, 4'h0);
    add(1, 8'h0E, 0, 8'hFF, 8'h00, 4'h0);
    add(1, 8'h1C, 0, 8'hFF, 8'h20, 4'h0);
    add(1, 8'h1B, 0, 8'hFF, 8'h22, 4'h0);
    add(1, 8'h23, 0, 8'hFF, 8'hA2, 4'h0);
    add(1, 8'h1C, 0, 8'hFF, 8'hA2, 4'h0);
    add(0, 8'h00, 0, 8'h08, 8'h02, 4'h0);
    add(0, 8'h00, 0, 8'h01, 8'h80, 4'h0);
    add(0, 8'h00, 0, 8'h00, 8'h00, 4'h0);
    add(0, 8'h00, 0, 8'h05, 8'hA0, 4'h0);

    // Reset state.
    settle(2);
    check("reset rowbits", 32'(rowbits), 32'h00);
    check("reset key_mod", 32'(key_mod), 32'h0);
    check("reset tx_wren", 32'(tx_wren), 32'h0);
    check("reset rx_rden", 32'(rx_rden), 32'h0);
    check("reset pulses", 32'({key_pause, key_clear}), 32'h0);

    // Release: exactly one F4 write.
    @(negedge clk);
    reset = 1'b0;
    settle(12);
    check("init tx count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("init tx byte", 32'(tx_log[0]), 32'hF4);

    foreach (vecs[i]) begin
      @(negedge clk);
      mask      = vecs[i].msk;
      rowselect = vecs[i].rsel;
      if (vecs[i].snd) send_and_settle(vecs[i].b);
      else             settle(2);
      check($sformatf("vec%0d rowbits", i), 32'(rowbits), 32'(vecs[i].rows));
      check($sformatf("vec%0d key_mod", i), 32'(key_mod), 32'(vecs[i].mods));
    end

    // Pause sequence: seven trailing bytes skipped, one pulse, no matrix change.
    rowselect = 8'hFF;
    p0 = pause_cnt;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    settle(6);
    check("pause pulses", 32'(pause_cnt - p0), 32'd1);
    check("pause rowbits", 32'(rowbits), 32'hA2);
    check("pause key_mod", 32'(key_mod), 32'h0);

    // Byte after Pause is decoded normally; break of a clear key is harmless.
    send_byte(8'hF0);
    send_and_settle(8'h14);
    check("break clear key", 32'(rowbits), 32'hA2);

    // Flush with keys and a modifier held.
    send_and_settle(8'h12);
    check("flush pre key_mod", 32'(key_mod), 32'h1);
    c0 = clear_cnt;
    send_and_settle(8'hAA);
    check("flush AA pulse", 32'(clear_cnt - c0), 32'd1);
    check("flush AA rowbits", 32'(rowbits), 32'h00);
    check("flush AA key_mod", 32'(key_mod), 32'h0);
    send_and_settle(8'h1B);
    send_and_settle(8'h00);
    check("flush 00 rowbits", 32'(rowbits), 32'h00);
    send_and_settle(8'h23);
    send_and_settle(8'hFF);
    check("flush FF rowbits", 32'(rowbits), 32'h00);
    check("flush total pulses", 32'(clear_cnt - c0), 32'd3);

    // Reset in the middle of an E0 F0 prefix: prefix dropped, F4 re-sent.
    send_byte(8'hE0);
    send_byte(8'hF0);
    settle(3);
    n0 = tx_log.size();
    @(negedge clk);
    reset = 1'b1;
    settle(2);
    @(negedge clk);
    reset = 1'b0;
    settle(12);
    check("rereset tx count", 32'(tx_log.size() - n0), 32'd1);
    if (tx_log.size() > n0) check("rereset tx byte", 32'(tx_log[n0]), 32'hF4);
    rowselect = 8'h04;
    send_and_settle(8'h1C);
    check("rereset make", 32'(rowbits), 32'h20);

`ifdef KEYS_LED_TX_EN
    // LED update: ED, FA reply, data byte, reply.
    n0 = tx_log.size();
    @(negedge clk);
    led_state = 3'b100;
    for (int i = 0; i < 40 && tx_log.size() == n0; i++) @(negedge clk);
    check("led cmd count", 32'(tx_log.size() - n0), 32'd1);
    if (tx_log.size() > n0) check("led cmd byte", 32'(tx_log[n0]), 32'hED);
    settle(6);
    send_byte(8'hFA);
    for (int i = 0; i < 40 && tx_log.size() == n0 + 1; i++) @(negedge clk);
    check("led data count", 32'(tx_log.size() - n0), 32'd2);
    if (tx_log.size() > n0 + 1) check("led data byte", 32'(tx_log[n0 + 1]), 32'h04);
    settle(6);
    send_and_settle(8'hFA);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
